// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Sequential ALU with single-cycle logic/arithmetic/shift operations and
//   iterative (one bit per cycle) unsigned multiply and restoring divide.
//   Results and the {V,C,N,Z} flag register are registered; out_valid pulses
//   for one cycle whenever a new result is presented.
//
// Ports
//   clk          single clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operation request
//   in_ready     request accepted this cycle (block is idle)
//   alu_op       opcode
//   op1, op2     operands (op2 also the shift count)
//   carry_sel    00 ALU carry, 01 force 1, 10 force 0, 11 hold previous C
//   flag_en      update the flag register with this operation
//   flag_regsel  0 ALU flags, 1 load pop_flags
//   pop_flags    flags restored from stack, {V,C,N,Z}
//   out_valid    one-cycle pulse, result/result_hi/flags valid
//   result       low result / quotient
//   result_hi    MUL high half / DIV remainder, else 0
//   flags        registered flags {V,C,N,Z}
//   busy         multi-cycle operation in progress
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       carry_sel,
    input  logic             flag_en,
    input  logic             flag_regsel,
    input  logic [3:0]       pop_flags,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work_hi, work_lo, op_m;
    logic             cap_flag_en, cap_regsel;
    logic [1:0]       cap_csel;
    logic [3:0]       cap_pop;

    logic accept, mul_start, div_start, multi_start, iterating, last_iter, load_result;

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = in_valid && in_ready;
    assign mul_start   = accept && (alu_op == 4'b1001);
    assign div_start   = accept && (alu_op == 4'b1010) && (op2 != '0);
    assign multi_start = mul_start || div_start;
    assign iterating   = (state == MUL) || (state == DIV);
    assign last_iter   = (cnt == CW'(WIDTH - 1));
    assign load_result = (accept && !multi_start) || (iterating && last_iter);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mul_start)      state_next = MUL;
                else if (div_start) state_next = DIV;
            end
            MUL, DIV: if (last_iter) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Single-cycle datapath. Shift carries come from widening the operand by
    // one bit so the last bit shifted out lands in the extra position.
    logic [WIDTH-1:0] alu_res, alu_hi;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   ext;
    logic [SHW:0]     shamt;

    assign shamt = op2[SHW:0];

    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        ext     = '0;
        case (alu_op)
            4'b0000: alu_res = ~op1;
            4'b0001: begin
                ext     = {1'b0, op1} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = !op1[WIDTH-1] && alu_res[WIDTH-1];
            end
            4'b0010: begin
                ext     = {1'b0, op1} - {{WIDTH{1'b0}}, 1'b1};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = op1[WIDTH-1] && !alu_res[WIDTH-1];
            end
            4'b0011: begin
                ext     = {1'b0, op1} + {1'b0, op2};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
            end
            4'b0100: begin
                ext     = {1'b0, op1} - {1'b0, op2};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
            end
            4'b0101: alu_res = op1 & op2;
            4'b0110: alu_res = op1 | op2;
            4'b0111: begin
                if (op2 == '0) begin
                    alu_res = op1;
                end else if (op2 <= W_VAL) begin
                    ext     = {1'b0, op1} << shamt;
                    alu_res = ext[WIDTH-1:0];
                    alu_c   = ext[WIDTH];
                end
            end
            4'b1000: begin
                if (op2 == '0) begin
                    alu_res = op1;
                end else if (op2 <= W_VAL) begin
                    ext     = {op1, 1'b0} >> shamt;
                    alu_res = ext[WIDTH:1];
                    alu_c   = ext[0];
                end
            end
            4'b1001: alu_res = '0;
            // Only reaches the result register when dividing by zero.
            4'b1010: begin
                alu_res = '1;
                alu_hi  = op1;
                alu_v   = 1'b1;
            end
            4'b1011: alu_res = op1 ^ op2;
            default: alu_res = op2;
        endcase
    end

    // One iteration of shift-add multiply (multiplier in work_lo, product
    // shifts right into it) or restoring divide (dividend shifts left out of
    // work_lo, quotient bits shift in; work_hi holds the partial remainder).
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic             div_ok;

    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_m} : '0);
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_m};
        div_ok    = !div_diff[WIDTH];
        if (state == MUL) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            iter_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            iter_lo = {work_lo[WIDTH-2:0], div_ok};
        end
    end

    // Selects what gets registered: live inputs for single-cycle operations,
    // captured controls and the final iteration for MUL/DIV.
    logic [WIDTH-1:0] fin_res, fin_hi;
    logic             fin_c, fin_v, fin_fe, fin_rs, sel_c;
    logic [1:0]       fin_cs;
    logic [3:0]       fin_pop, flags_next;

    always_comb begin
        if (iterating) begin
            fin_res = iter_lo;
            fin_hi  = iter_hi;
            fin_c   = 1'b0;
            fin_v   = (state == MUL) && (iter_hi != '0);
            fin_fe  = cap_flag_en;
            fin_rs  = cap_regsel;
            fin_cs  = cap_csel;
            fin_pop = cap_pop;
        end else begin
            fin_res = alu_res;
            fin_hi  = alu_hi;
            fin_c   = alu_c;
            fin_v   = alu_v;
            fin_fe  = flag_en;
            fin_rs  = flag_regsel;
            fin_cs  = carry_sel;
            fin_pop = pop_flags;
        end
        case (fin_cs)
            2'b00:   sel_c = fin_c;
            2'b01:   sel_c = 1'b1;
            2'b10:   sel_c = 1'b0;
            default: sel_c = flags[2];
        endcase
        flags_next = fin_rs ? fin_pop : {fin_v, sel_c, fin_res[WIDTH-1], (fin_res == '0)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            op_m        <= '0;
            cap_flag_en <= 1'b0;
            cap_regsel  <= 1'b0;
            cap_csel    <= 2'b00;
            cap_pop     <= 4'h0;
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            flags       <= 4'h0;
        end else begin
            state     <= state_next;
            out_valid <= load_result;
            if (load_result) begin
                result    <= fin_res;
                result_hi <= fin_hi;
                if (fin_fe) flags <= flags_next;
            end
            if (multi_start) begin
                cnt         <= '0;
                work_hi     <= '0;
                work_lo     <= mul_start ? op2 : op1;
                op_m        <= mul_start ? op1 : op2;
                cap_flag_en <= flag_en;
                cap_regsel  <= flag_regsel;
                cap_csel    <= carry_sel;
                cap_pop     <= pop_flags;
            end else if (iterating) begin
                work_hi <= iter_hi;
                work_lo <= iter_lo;
                cnt     <= last_iter ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu at WIDTH=16.
module tb_multicycle_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [15:0] op1, op2;
    logic [1:0]  carry_sel;
    logic        flag_en, flag_regsel;
    logic [3:0]  pop_flags;
    logic        out_valid;
    logic [15:0] result, result_hi;
    logic [3:0]  flags;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    multicycle_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op1(op1), .op2(op2), .carry_sel(carry_sel),
        .flag_en(flag_en), .flag_regsel(flag_regsel), .pop_flags(pop_flags),
        .out_valid(out_valid), .result(result), .result_hi(result_hi),
        .flags(flags), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request; called just after a falling edge.
    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] cs, input logic fe, input logic rs, input logic [3:0] pf);
        alu_op      = op;
        op1         = a;
        op2         = b;
        carry_sel   = cs;
        flag_en     = fe;
        flag_regsel = rs;
        pop_flags   = pf;
        in_valid    = 1'b1;
    endtask

    // Counts falling edges after acceptance until out_valid, noting whether
    // in_ready was ever seen high in the meantime. lat=0 means timeout.
    task automatic wait_done(output int lat, output logic ready_seen);
        lat        = 0;
        ready_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1'b1;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        drive(4'b0011, 16'h0001, 16'h0001, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0 || result_hi !== 16'h0 || flags !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got ov=%b res=%h hi=%h fl=%h exp 0/0000/0000/0",
                     out_valid, result, result_hi, flags);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready got rdy=%b busy=%b exp 1/0", in_ready, busy);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_add_flags;
        @(negedge clk);
        drive(4'b0011, 16'h7FFF, 16'h0001, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h8000 || result_hi !== 16'h0000 || flags !== 4'hA) begin
            failures++;
            $display("[TB] FAIL add_overflow got ov=%b res=%h hi=%h fl=%h exp 1/8000/0000/a",
                     out_valid, result, result_hi, flags);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h8000) begin
            failures++;
            $display("[TB] FAIL add_hold got ov=%b res=%h exp 0/8000", out_valid, result);
        end
    endtask

    // Table: op, op1, op2, carry_sel, expected result, expected flags {V,C,N,Z}.
    task automatic test_single_ops;
        logic [3:0]  t_op [14]  = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'hB, 4'hF, 4'h3, 4'h3, 4'h1,
                                    4'h7, 4'h8, 4'h7};
        logic [15:0] t_a  [14]  = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h8000, 16'hF0F0, 16'hF0F0, 16'h1234,
                                    16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h1234, 16'h8000, 16'h0001};
        logic [15:0] t_b  [14]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h3C3C, 16'h0F00, 16'h1234,
                                    16'hABCD, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'd16, 16'd16};
        logic [1:0]  t_cs [14]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11,
                                    2'b10, 2'b00, 2'b00, 2'b00};
        logic [15:0] t_res[14]  = '{16'hFF00, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h3030, 16'hFFF0, 16'h0000,
                                    16'hABCD, 16'h0002, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
        logic [3:0]  t_fl [14]  = '{4'h2, 4'h5, 4'h6, 4'h8, 4'h0, 4'h2, 4'h1, 4'h2, 4'h4, 4'h5, 4'h1,
                                    4'h0, 4'h5, 4'h5};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(t_op[i], t_a[i], t_b[i], t_cs[i], 1'b1, 1'b0, 4'h0);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || result !== t_res[i] || flags !== t_fl[i] || result_hi !== 16'h0) begin
                failures++;
                $display("[TB] FAIL single_op[%0d] got ov=%b res=%h hi=%h fl=%h exp 1/%h/0000/%h",
                         i, out_valid, result, result_hi, flags, t_res[i], t_fl[i]);
            end
        end
    endtask

    task automatic test_shift;
        @(negedge clk);
        drive(4'b0111, 16'h8001, 16'd1, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        checks++;
        if (result !== 16'h0002 || flags !== 4'h4) begin
            failures++;
            $display("[TB] FAIL shl_8001_1 got res=%h fl=%h exp 0002/4", result, flags);
        end
        drive(4'b1000, 16'h0003, 16'd20, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        checks++;
        if (result !== 16'h0000 || flags !== 4'h1 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL shr_0003_20 got res=%h fl=%h ov=%b exp 0000/1/1", result, flags, out_valid);
        end
        drive(4'b1000, 16'h0003, 16'd1, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (result !== 16'h0001 || flags !== 4'h4) begin
            failures++;
            $display("[TB] FAIL shr_0003_1 got res=%h fl=%h exp 0001/4", result, flags);
        end
    endtask

    task automatic test_mul;
        int   lat;
        logic rdy;
        @(negedge clk);
        drive(4'b1001, 16'hFFFF, 16'h0002, 2'b00, 1'b1, 1'b0, 4'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(lat, rdy);
        checks++;
        if (lat != 17) begin
            failures++;
            $display("[TB] FAIL mul_latency got %0d exp 17", lat);
        end
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mul_ready_low got ready_or_idle_seen=%b exp 0", rdy);
        end
        checks++;
        if (result !== 16'hFFFE || result_hi !== 16'h0001 || flags !== 4'hA) begin
            failures++;
            $display("[TB] FAIL mul_ffff_2 got res=%h hi=%h fl=%h exp fffe/0001/a", result, result_hi, flags);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'hFFFE) begin
            failures++;
            $display("[TB] FAIL mul_after got ov=%b rdy=%b res=%h exp 0/1/fffe", out_valid, in_ready, result);
        end
        drive(4'b1001, 16'hFFFF, 16'hFFFF, 2'b00, 1'b1, 1'b0, 4'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(lat, rdy);
        checks++;
        if (lat != 17 || result !== 16'h0001 || result_hi !== 16'hFFFE || flags !== 4'h8) begin
            failures++;
            $display("[TB] FAIL mul_ffff_ffff got lat=%0d res=%h hi=%h fl=%h exp 17/0001/fffe/8",
                     lat, result, result_hi, flags);
        end
    endtask

    task automatic test_div;
        int   lat;
        logic rdy;
        @(negedge clk);
        drive(4'b1010, 16'd100, 16'd7, 2'b00, 1'b1, 1'b0, 4'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(lat, rdy);
        checks++;
        if (lat != 17 || rdy !== 1'b0 || result !== 16'd14 || result_hi !== 16'd2 || flags !== 4'h0) begin
            failures++;
            $display("[TB] FAIL div_100_7 got lat=%0d rdy=%b res=%h hi=%h fl=%h exp 17/0/000e/0002/0",
                     lat, rdy, result, result_hi, flags);
        end
        @(negedge clk);
        drive(4'b1010, 16'd5, 16'd0, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'hFFFF || result_hi !== 16'd5 || flags !== 4'hA
            || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL div_by_zero got ov=%b res=%h hi=%h fl=%h rdy=%b exp 1/ffff/0005/a/1",
                     out_valid, result, result_hi, flags, in_ready);
        end
    endtask

    task automatic test_flag_regsel;
        @(negedge clk);
        drive(4'b0101, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        checks++;
        if (flags !== 4'h1) begin
            failures++;
            $display("[TB] FAIL flags_pre got %h exp 1", flags);
        end
        drive(4'b0011, 16'h0001, 16'h0001, 2'b00, 1'b1, 1'b1, 4'hA);
        @(negedge clk);
        checks++;
        if (flags !== 4'hA || result !== 16'h0002) begin
            failures++;
            $display("[TB] FAIL flags_pop got fl=%h res=%h exp a/0002", flags, result);
        end
        drive(4'b0100, 16'h0003, 16'h0003, 2'b00, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (flags !== 4'hA || result !== 16'h0000 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flags_hold got fl=%h res=%h ov=%b exp a/0000/1", flags, result, out_valid);
        end
    endtask

    task automatic test_reset_mid_mul;
        int pulses;
        @(negedge clk);
        drive(4'b1001, 16'hFFFF, 16'h0002, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0 || result_hi !== 16'h0 || flags !== 4'h0
            || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_mul_reset got ov=%b res=%h hi=%h fl=%h rdy=%b busy=%b exp 0/0/0/0/1/0",
                     out_valid, result, result_hi, flags, in_ready, busy);
        end
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("[TB] FAIL mid_mul_no_pulse got %0d pulses exp 0", pulses);
        end
        drive(4'b0011, 16'h0002, 16'h0003, 2'b00, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0005 || flags !== 4'h0) begin
            failures++;
            $display("[TB] FAIL post_reset_add got ov=%b res=%h fl=%h exp 1/0005/0", out_valid, result, flags);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  b_op [3] = '{4'h3, 4'h4, 4'hB};
        logic [15:0] b_a  [3] = '{16'h0001, 16'h000A, 16'hF0F0};
        logic [15:0] b_b  [3] = '{16'h0002, 16'h0004, 16'hFFFF};
        logic [15:0] b_res[3] = '{16'h0003, 16'h0006, 16'h0F0F};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(b_op[i], b_a[i], b_b[i], 2'b00, 1'b1, 1'b0, 4'h0);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== b_res[i]) begin
                failures++;
                $display("[TB] FAIL back_to_back[%0d] got ov=%b rdy=%b res=%h exp 1/1/%h",
                         i, out_valid, in_ready, result, b_res[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_op      = 4'h0;
        op1         = '0;
        op2         = '0;
        carry_sel   = 2'b00;
        flag_en     = 1'b0;
        flag_regsel = 1'b0;
        pop_flags   = 4'h0;
        test_reset();
        test_add_flags();
        test_single_ops();
        test_shift();
        test_mul();
        test_div();
        test_flag_regsel();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width (legal 8..32).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-count compare width.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  operation request.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 The block SHALL have port alu_op  input  4  opcode.
REQ-008 The block SHALL have port op1  input  WIDTH  first operand.
REQ-009 The block SHALL have port op2  input  WIDTH  second operand / shift count.
REQ-010 The block SHALL have port carry_sel  input  2  00 ALU carry, 01 force 1, 10 force 0, 11 hold previous C.
REQ-011 The block SHALL have port flag_en  input  1  update flag register with this operation.
REQ-012 The block SHALL have port flag_regsel  input  1  0 ALU flags, 1 load pop_flags.
REQ-013 The block SHALL have port pop_flags  input  4  flags restored from stack, {V,C,N,Z}.
REQ-014 The block SHALL have port out_valid  output  1  one-cycle pulse, result/result_hi/flags valid.
REQ-015 The block SHALL have port result  output  WIDTH  low result / quotient.
REQ-016 The block SHALL have port result_hi  output  WIDTH  MUL high half / DIV remainder, else 0.
REQ-017 The block SHALL have port flags  output  4  registered flags {V,C,N,Z}.
REQ-018 The block SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-019 Opcodes SHALL be: 0000 NOT op1; 0001 op1+1; 0010 op1-1; 0011 op1+op2; 0100 op1-op2; 0101 AND; 0110 OR; 0111 SHL op1 by op2; 1000 SHR (logical) op1 by op2; 1001 MUL unsigned; 1010 DIV unsigned; 1011 XOR; others pass op2.
REQ-020 Handshake: request accepted on rising edge with in_valid=1 and in_ready=1; in_ready SHALL equal (state==IDLE); operands, opcode, flag_en, flag_regsel, carry_sel, pop_flags captured at acceptance.
REQ-021 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL/DIV on accepting 1001/1010 (op2!=0 for DIV); MUL/DIV->DONE after exactly WIDTH iteration cycles; DONE->IDLE unconditionally; busy=1 in MUL, DIV, DONE.
REQ-022 Single-cycle ops and DIV-by-zero SHALL register results at the accepting edge: out_valid=1 the following cycle, state stays IDLE (back-to-back issue every cycle).
REQ-023 MUL/DIV: out_valid=1 for the one cycle in DONE, i.e. WIDTH+1 cycles after acceptance; no request accepted until back in IDLE.
REQ-024 MUL: shift-add, one bit per cycle, {result_hi,result} = 2*WIDTH-bit product.
REQ-025 DIV: restoring, one bit per cycle, result=quotient, result_hi=remainder; op2==0 -> result all ones, result_hi=op1, V=1.
REQ-026 Shifts: amount = full op2 value; 0 -> result=op1, C=0; 1..WIDTH -> C = last bit shifted out; >WIDTH -> result=0, C=0.
REQ-027 ALU C: carry-out for ADD/INC, borrow for SUB/DEC, shift per REQ-026, 0 otherwise.
REQ-028 V: signed overflow for ADD/SUB/INC/DEC; MUL V=1 iff result_hi!=0; DIV per REQ-025; 0 otherwise.
REQ-029 N=result[WIDTH-1], Z=(result==0), computed on low result only.
REQ-030 Flag register SHALL update on the same edge that registers the result, only if captured flag_en=1: flag_regsel=1 -> pop_flags; else {V, carry_sel-selected C, N, Z}; flag_en=0 -> flags unchanged.
REQ-031 result/result_hi SHALL hold last value when out_valid=0.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force state IDLE, result=0, result_hi=0, flags=0, out_valid=0, iteration counter=0; in_ready=1 and busy=0 from the next cycle.
REQ-033 Reset mid MUL/DIV SHALL abort with no out_valid pulse; rst_n=0 overrides a same-cycle request.

Verification
REQ-034 ADD 0x7FFF+0x0001, flag_en=1, carry_sel=00 -> next cycle out_valid=1, result=0x8000, flags V=1,C=0,N=1,Z=0.
REQ-035 MUL 0xFFFF*0x0002 -> out_valid exactly 17 cycles after accept, result=0xFFFE, result_hi=0x0001, V=1, in_ready=0 throughout.
REQ-036 DIV 100/7 -> result=14, result_hi=2 at cycle 17; DIV 5/0 -> next cycle result=0xFFFF, result_hi=5, V=1.
REQ-037 SHL 0x8001 by 1 -> result=0x0002, C=1; SHR 0x0003 by 20 -> result=0, C=0, Z=1.
REQ-038 flag_regsel=1, pop_flags=0xA with flag_en=1 -> flags=0xA; then SUB 3-3 flag_en=0 -> flags still 0xA.
REQ-039 rst_n=0 at cycle 5 of MUL -> no out_valid, outputs zero, in_ready=1 next cycle, new ADD accepted normally.
